seven_segment_monitor: RTL and testbench

Passive decoder for the board's multiplexed eight-digit seven-segment display bus. It samples the active-low anode and cathode lines, and decodes the lit glyph on each digit once that digit has dwelt long enough. It reassembles a full scan into the 16-bit value being shown. It sits beside the display driver as a loopback checker, letting the distance pipeline and the display path be verified against each other on hardware and in simulation.

---
 rtl/seven_segment_monitor.sv | 155 +++++++++++++++
 tb/tb_seven_segment_monitor.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_monitor.sv
// rtl/seven_segment_monitor.sv - passive decoder for a multiplexed eight-digit seven-segment bus
module seven_segment_monitor #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [7:0]  an_in,
    input  logic [6:0]  cat_in,
    output logic [15:0] value_out,
    output logic        value_valid_out,
    output logic        loading_out,
    output logic        glyph_err_out
);

    localparam logic [15:0] SETTLE    = 16'(SETTLE_CYCLES);
    localparam logic [15:0] SETTLE_M1 = 16'(SETTLE_CYCLES - 1);

    logic [7:0]  an_meta, an_sync, an_prev;
    logic [6:0]  cat_meta, cat_sync, cat_prev;
    logic [15:0] stable_cnt;

    logic        same;
    logic        capture;
    logic [2:0]  dec_idx;
    logic [3:0]  dec_nib;
    logic        dec_legal;

    logic        cap_pend;
    logic [2:0]  cap_idx;
    logic [3:0]  cap_nib;
    logic        cap_legal;

    logic [31:0] digits, digits_upd;
    logic [7:0]  seen, seen_upd;
    logic        frame_close, frame_full, all_loading;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            an_meta    <= '1;
            an_sync    <= '1;
            an_prev    <= '1;
            cat_meta   <= '1;
            cat_sync   <= '1;
            cat_prev   <= '1;
            stable_cnt <= '0;
        end else begin
            an_meta  <= an_in;
            an_sync  <= an_meta;
            an_prev  <= an_sync;
            cat_meta <= cat_in;
            cat_sync <= cat_meta;
            cat_prev <= cat_sync;
            if (!same) begin
                stable_cnt <= 16'd1;
            end else if (stable_cnt < SETTLE) begin
                stable_cnt <= stable_cnt + 16'd1;
            end
        end
    end

    // Capture on the edge the counter steps onto SETTLE, so a saturated dwell never recaptures.
    assign same    = ({an_sync, cat_sync} == {an_prev, cat_prev});
    assign capture = same && (stable_cnt == SETTLE_M1) && $onehot(~an_sync);

    always_comb begin
        dec_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!an_sync[i]) begin
                dec_idx = 3'(i);
            end
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_nib   = 4'h0;
        case (~cat_sync)
            7'h3F: dec_nib = 4'h0;
            7'h06: dec_nib = 4'h1;
            7'h5B: dec_nib = 4'h2;
            7'h4F: dec_nib = 4'h3;
            7'h66: dec_nib = 4'h4;
            7'h6D: dec_nib = 4'h5;
            7'h7D: dec_nib = 4'h6;
            7'h07: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h6F: dec_nib = 4'h9;
            7'h77: dec_nib = 4'hA;
            7'h7C: dec_nib = 4'hB;
            7'h39: dec_nib = 4'hC;
            7'h5E: dec_nib = 4'hD;
            7'h79: dec_nib = 4'hE;
            7'h71: dec_nib = 4'hF;
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cap_pend  <= 1'b0;
            cap_idx   <= 3'd0;
            cap_nib   <= 4'h0;
            cap_legal <= 1'b0;
        end else begin
            cap_pend  <= capture;
            cap_idx   <= dec_idx;
            cap_nib   <= dec_nib;
            cap_legal <= dec_legal;
        end
    end

    // Frame decision sees the digit/seen state including the capture being applied.
    always_comb begin
        digits_upd = digits;
        seen_upd   = seen;
        if (cap_legal) begin
            digits_upd[cap_idx*4 +: 4] = cap_nib;
            seen_upd[cap_idx]          = 1'b1;
        end else begin
            seen_upd[cap_idx] = 1'b0;
        end
        frame_close = cap_pend && (cap_idx == 3'd7);
        frame_full  = (seen_upd == 8'hFF);
        all_loading = (digits_upd == 32'hAAAA_AAAA);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            digits          <= '0;
            seen            <= '0;
            value_out       <= '0;
            value_valid_out <= 1'b0;
            loading_out     <= 1'b0;
            glyph_err_out   <= 1'b0;
        end else begin
            value_valid_out <= 1'b0;
            glyph_err_out   <= 1'b0;
            if (cap_pend) begin
                digits        <= digits_upd;
                seen          <= frame_close ? 8'h00 : seen_upd;
                glyph_err_out <= !cap_legal;
                if (frame_close && frame_full) begin
                    if (all_loading) begin
                        loading_out <= 1'b1;
                    end else begin
                        value_out       <= digits_upd[15:0];
                        value_valid_out <= 1'b1;
                        loading_out     <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// tb/tb_seven_segment_monitor.sv - directed scans checked against a dwell/frame model of the display monitor
module tb_seven_segment_monitor;

    localparam int SETTLE = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  an = 8'hFF;
    logic [6:0]  cat = 7'h7F;
    logic [15:0] value_out;
    logic        value_valid_out;
    logic        loading_out;
    logic        glyph_err_out;

    seven_segment_monitor #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .an_in           (an),
        .cat_in          (cat),
        .value_out       (value_out),
        .value_valid_out (value_valid_out),
        .loading_out     (loading_out),
        .glyph_err_out   (glyph_err_out)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int last_valid_cyc = -1;
    int t7 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    typedef struct {
        logic        v;
        logic        err;
        logic [15:0] value;
        logic        load;
    } exp_t;

    exp_t        q [3];
    exp_t        e;
    logic [14:0] m_last;
    int          m_run;
    logic [3:0]  m_dig [8];
    logic [7:0]  m_seen;
    logic [15:0] m_value;
    logic        m_load;

    // Model: a pin pattern held for SETTLE consecutive edges is captured; results surface three edges later.
    task automatic model_step();
        exp_t nw;
        int   idx;
        int   found;
        bit   all_a;
        if (!rst_n) begin
            m_last  = '1;
            m_run   = 0;
            m_seen  = '0;
            m_value = '0;
            m_load  = 1'b0;
            for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
            e = '{1'b0, 1'b0, 16'h0, 1'b0};
            for (int i = 0; i < 3; i++) q[i] = e;
            return;
        end
        e    = q[2];
        q[2] = q[1];
        q[1] = q[0];
        if ({an, cat} == m_last) m_run = (m_run > SETTLE) ? m_run : m_run + 1;
        else m_run = 1;
        m_last = {an, cat};
        nw = '{1'b0, 1'b0, m_value, m_load};
        if (m_run == SETTLE && $countones(~an) == 1) begin
            idx = 0;
            for (int i = 0; i < 8; i++) if (!an[i]) idx = i;
            found = -1;
            for (int k = 0; k < 16; k++) if (glyph_tab[k] == ~cat) found = k;
            if (found >= 0) begin
                m_dig[idx]  = 4'(found);
                m_seen[idx] = 1'b1;
            end else begin
                m_seen[idx] = 1'b0;
                nw.err      = 1'b1;
            end
            if (idx == 7) begin
                if (m_seen == 8'hFF) begin
                    all_a = 1;
                    for (int i = 0; i < 8; i++) if (m_dig[i] != 4'hA) all_a = 0;
                    if (all_a) begin
                        m_load = 1'b1;
                    end else begin
                        m_value = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
                        nw.v    = 1'b1;
                        m_load  = 1'b0;
                    end
                end
                m_seen = '0;
            end
            nw.value = m_value;
            nw.load  = m_load;
        end
        q[0] = nw;
    endtask

    always @(posedge clk) begin
        cyc++;
        model_step();
        #1;
        chk("value_valid_out", 32'(value_valid_out), 32'(e.v));
        chk("glyph_err_out",   32'(glyph_err_out),   32'(e.err));
        chk("value_out",       32'(value_out),       32'(e.value));
        chk("loading_out",     32'(loading_out),     32'(e.load));
        if (value_valid_out) begin
            valid_cnt++;
            last_valid_cyc = cyc;
        end
        if (glyph_err_out) err_cnt++;
    end

    task automatic show(input int idx, input logic [6:0] seg, input int dwell);
        @(negedge clk);
        an  = ~(8'h01 << idx);
        cat = ~seg;
        if (idx == 7) t7 = cyc + 1;
        repeat (dwell - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        an  = 8'hFF;
        cat = 7'h7F;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic scan(input logic [31:0] digs, input logic [7:0] blank, input int first,
                        input int last, input int dwell);
        for (int i = first; i <= last; i++) begin
            show(i, blank[i] ? 7'h00 : glyph_tab[digs[i*4 +: 4]], dwell);
        end
    endtask

    int v0, e0;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset value_out", 32'(value_out), 32'h0);
        chk("reset loading_out", 32'(loading_out), 32'h0);
        rst_n = 1'b1;
        idle(4);

        scan(32'hAAAA_AAAA, 8'h00, 0, 7, 20);
        idle(5);
        chk("loading set", 32'(loading_out), 32'h1);
        chk("loading no valid", 32'(valid_cnt), 32'h0);
        chk("loading value", 32'(value_out), 32'h0);

        scan(32'h0000_1234, 8'h00, 0, 7, 20);
        idle(5);
        chk("value frame valid count", 32'(valid_cnt), 32'h1);
        chk("value frame latency", 32'(last_valid_cyc - t7), 32'd18);
        chk("value frame value", 32'(value_out), 32'h1234);
        chk("value frame loading", 32'(loading_out), 32'h0);

        v0 = valid_cnt; e0 = err_cnt;
        scan(32'h0000_5678, 8'h00, 0, 7, 10);
        idle(5);
        chk("short dwell valid", 32'(valid_cnt - v0), 32'h0);
        chk("short dwell err", 32'(err_cnt - e0), 32'h0);
        chk("short dwell value", 32'(value_out), 32'h1234);

        scan(32'h89AB_C0DE, 8'h00, 0, 7, 20);
        idle(5);
        chk("mixed frame value", 32'(value_out), 32'hC0DE);

        v0 = valid_cnt; e0 = err_cnt;
        scan(32'h0000_1234, 8'h04, 0, 7, 20);
        idle(5);
        chk("bad glyph err", 32'(err_cnt - e0), 32'h1);
        chk("bad glyph no valid", 32'(valid_cnt - v0), 32'h0);
        scan(32'h0000_1234, 8'h00, 0, 7, 20);
        idle(5);
        chk("after bad valid", 32'(valid_cnt - v0), 32'h1);
        chk("after bad value", 32'(value_out), 32'h1234);

        v0 = valid_cnt;
        scan(32'h0000_4321, 8'h00, 0, 3, 20);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid-scan reset value", 32'(value_out), 32'h0);
        rst_n = 1'b1;
        scan(32'h0000_4321, 8'h00, 4, 7, 20);
        idle(5);
        chk("partial scan no valid", 32'(valid_cnt - v0), 32'h0);
        scan(32'h0000_4321, 8'h00, 0, 7, 20);
        idle(5);
        chk("rescan valid", 32'(valid_cnt - v0), 32'h1);
        chk("rescan value", 32'(value_out), 32'h4321);

        v0 = valid_cnt; e0 = err_cnt;
        @(negedge clk);
        an  = 8'b1111_1100;
        cat = ~glyph_tab[1];
        repeat (40) @(negedge clk);
        idle(5);
        chk("two anodes valid", 32'(valid_cnt - v0), 32'h0);
        chk("two anodes err", 32'(err_cnt - e0), 32'h0);
        scan(32'h0000_0000, 8'h00, 4, 7, 20);
        idle(5);
        chk("two anodes seen untouched", 32'(valid_cnt - v0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
